// File: rtl/writeback_retire_if.sv
// writeback_retire_if: exec-result, CSR, resume and commit signals of the writeback stage
interface writeback_retire_if #(parameter int XLEN = 64, parameter int ALEN = 64, parameter int CNT_W = 64);
  logic             exec_stall_next;
  logic             exec_exception;
  logic             exec_is_branch;
  logic             exec_is_reg_write;
  logic [4:0]       exec_reg_write_sel;
  logic [XLEN-1:0]  exec_result;
  logic [ALEN-1:0]  exec_branch_target;
  logic [ALEN-1:0]  exec_instruction_next_addr;
  logic             csr_instret_we;
  logic [CNT_W-1:0] csr_instret_wdata;
  logic             resume;
  logic [ALEN-1:0]  resume_addr;
  logic             reg_write_en;
  logic [4:0]       reg_write_sel;
  logic [XLEN-1:0]  reg_write_data;
  logic             retire_valid;
  logic [ALEN-1:0]  retire_next_pc;
  logic             trap_valid;
  logic [ALEN-1:0]  trap_next_addr;
  logic             halted;
  logic             redirect_valid;
  logic [ALEN-1:0]  redirect_addr;
  logic [CNT_W-1:0] instret;
  modport slave (
    input  exec_stall_next, exec_exception, exec_is_branch, exec_is_reg_write, exec_reg_write_sel,
           exec_result, exec_branch_target, exec_instruction_next_addr, csr_instret_we,
           csr_instret_wdata, resume, resume_addr,
    output reg_write_en, reg_write_sel, reg_write_data, retire_valid, retire_next_pc, trap_valid,
           trap_next_addr, halted, redirect_valid, redirect_addr, instret
  );
  modport master (
    output exec_stall_next, exec_exception, exec_is_branch, exec_is_reg_write, exec_reg_write_sel,
           exec_result, exec_branch_target, exec_instruction_next_addr, csr_instret_we,
           csr_instret_wdata, resume, resume_addr,
    input  reg_write_en, reg_write_sel, reg_write_data, retire_valid, retire_next_pc, trap_valid,
           trap_next_addr, halted, redirect_valid, redirect_addr, instret
  );
endinterface

// File: rtl/writeback_retire.sv
// writeback_retire: commits exec results, counts instret, turns exceptions into trap then halt
module writeback_retire #(parameter int XLEN = 64, parameter int ALEN = 64, parameter int CNT_W = 64) (
  input logic clk,
  input logic rst,
  writeback_retire_if.slave bus
);
  typedef enum logic [1:0] {RUN, TRAP, HALTED} state_t;
  state_t state_q, state_d;
  logic reg_write_en_q, reg_write_en_d, retire_valid_q, retire_valid_d;
  logic trap_valid_q, trap_valid_d, halted_q, halted_d, redirect_valid_q, redirect_valid_d;
  logic [4:0] reg_write_sel_q, reg_write_sel_d;
  logic [XLEN-1:0] reg_write_data_q, reg_write_data_d;
  logic [ALEN-1:0] retire_next_pc_q, retire_next_pc_d, trap_next_addr_q, trap_next_addr_d;
  logic [ALEN-1:0] redirect_addr_q, redirect_addr_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic in_valid, ok, wr;
  always_comb begin
    in_valid = !bus.exec_stall_next && state_q == RUN;
    ok = in_valid && !bus.exec_exception;
    wr = ok && bus.exec_is_reg_write && bus.exec_reg_write_sel != 5'd0;
    state_d = state_q == TRAP ? HALTED
            : state_q == HALTED ? (bus.resume ? RUN : HALTED)
            : (in_valid && bus.exec_exception ? TRAP : RUN);
    reg_write_en_d = wr;
    reg_write_sel_d = wr ? bus.exec_reg_write_sel : (state_q == RUN && !in_valid ? 5'd0 : reg_write_sel_q);
    reg_write_data_d = wr ? bus.exec_result : reg_write_data_q;
    retire_valid_d = ok;
    retire_next_pc_d = !ok ? retire_next_pc_q
                     : bus.exec_is_branch ? bus.exec_branch_target : bus.exec_instruction_next_addr;
    trap_valid_d = in_valid && bus.exec_exception;
    trap_next_addr_d = trap_valid_d ? bus.exec_instruction_next_addr : trap_next_addr_q;
    halted_d = state_d == HALTED;
    redirect_valid_d = state_q == HALTED && bus.resume;
    redirect_addr_d = redirect_valid_d ? bus.resume_addr : redirect_addr_q;
    // a CSR write overrides a same-cycle retire increment
    instret_d = bus.csr_instret_we ? bus.csr_instret_wdata : instret_q + CNT_W'(ok);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      reg_write_en_q <= 1'b0;
      reg_write_sel_q <= '0;
      reg_write_data_q <= '0;
      retire_valid_q <= 1'b0;
      retire_next_pc_q <= '0;
      trap_valid_q <= 1'b0;
      trap_next_addr_q <= '0;
      halted_q <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_addr_q <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      reg_write_en_q <= reg_write_en_d;
      reg_write_sel_q <= reg_write_sel_d;
      reg_write_data_q <= reg_write_data_d;
      retire_valid_q <= retire_valid_d;
      retire_next_pc_q <= retire_next_pc_d;
      trap_valid_q <= trap_valid_d;
      trap_next_addr_q <= trap_next_addr_d;
      halted_q <= halted_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_addr_q <= redirect_addr_d;
      instret_q <= instret_d;
    end
  end
  assign bus.reg_write_en = reg_write_en_q;
  assign bus.reg_write_sel = reg_write_sel_q;
  assign bus.reg_write_data = reg_write_data_q;
  assign bus.retire_valid = retire_valid_q;
  assign bus.retire_next_pc = retire_next_pc_q;
  assign bus.trap_valid = trap_valid_q;
  assign bus.trap_next_addr = trap_next_addr_q;
  assign bus.halted = halted_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_addr = redirect_addr_q;
  assign bus.instret = instret_q;
endmodule

// File: doc/writeback_retire.md
Name: writeback_retire

Overview:
- Final pipeline stage. Consumes exec results and commits them.
- Drives the register-file write port and the writeback bypass back to decode.
- Tracks the retired-instruction count (instret) and the architectural next PC.
- Converts an exec exception into a one-shot trap report, then a halted state that only an explicit resume leaves.

Parameters:
XLEN, 64, data width of results and register-file writes
ALEN, 64, address width of PCs and branch targets
CNT_W, 64, width of the instret counter

Ports:
clk  input  1  clock
rst  input  1  reset: synchronous, active-high; clock clk
exec_stall_next  input  1  high = exec output not valid this cycle
exec_exception  input  1  exec output carries an exception
exec_is_branch  input  1  retiring instr is a taken branch/jump
exec_is_reg_write  input  1  retiring instr writes rd
exec_reg_write_sel  input  5  rd index
exec_result  input  XLEN  result data
exec_branch_target  input  ALEN  target when exec_is_branch
exec_instruction_next_addr  input  ALEN  address following the retiring instr
csr_instret_we  input  1  software write to instret
csr_instret_wdata  input  CNT_W  instret write value
resume  input  1  leave HALTED
resume_addr  input  ALEN  PC to restart at
reg_write_en  output  1  register-file write strobe
reg_write_sel  output  5  register-file write index
reg_write_data  output  XLEN  register-file write data
retire_valid  output  1  one instr retired last cycle (pulse)
retire_next_pc  output  ALEN  architectural PC after that instr
trap_valid  output  1  trap report (pulse)
trap_next_addr  output  ALEN  next_addr of the faulting instr
halted  output  1  stage is in HALTED
redirect_valid  output  1  fetch restart request (pulse)
redirect_addr  output  ALEN  fetch restart address
instret  output  CNT_W  retired-instruction counter

Behaviour:
- All outputs are registered.
- Reset values:
  - reg_write_en=0, reg_write_sel=0, reg_write_data=0.
  - retire_valid=0, retire_next_pc=0.
  - trap_valid=0, trap_next_addr=0.
  - halted=0, redirect_valid=0, redirect_addr=0.
  - instret=0, state=RUN.
- Reset mid-operation (including during HALTED or TRAP) returns to RUN with these reset values at the next edge.
- States: RUN, TRAP, HALTED.
- in_valid = !exec_stall_next && state==RUN. There is no backpressure to exec: every in_valid cycle is consumed.
- RUN, in_valid && !exec_exception:
  - Next cycle: retire_valid=1.
  - retire_next_pc = exec_is_branch ? exec_branch_target : exec_instruction_next_addr.
  - instret += 1, modulo 2^CNT_W; all-ones wraps to 0.
  - If exec_is_reg_write && exec_reg_write_sel!=0: reg_write_en=1, reg_write_sel=sel, reg_write_data=exec_result.
  - Otherwise reg_write_en=0; reg_write_sel and reg_write_data are held.
  - Latency is 1 cycle from the input cycle to the write strobe.
- RUN, in_valid && exec_exception:
  - Next cycle: state=TRAP, trap_valid=1, trap_next_addr=exec_instruction_next_addr.
  - No register write, no retire_valid, no instret increment.
- RUN, !in_valid:
  - reg_write_en=0, retire_valid=0.
  - reg_write_sel returns to 0 so the decode bypass compare cannot match a stale index.
- TRAP: lasts exactly 1 cycle, then HALTED. trap_valid drops.
- HALTED:
  - halted=1. All exec inputs are ignored, even if exec_stall_next=0.
  - resume=1: next cycle state=RUN, halted=0, redirect_valid=1, redirect_addr=resume_addr.
  - resume in RUN or TRAP is ignored.
- In TRAP or HALTED: reg_write_en=0, retire_valid=0.
- A resume that takes effect in the same cycle exec presents a valid output: the exec output is dropped, because state is not yet RUN.
- redirect_valid is a 1-cycle pulse; redirect_addr holds its last value.
- instret write:
  - csr_instret_we loads csr_instret_wdata. This is honoured in every state.
  - Simultaneous CSR write and retire increment: the write wins, and the increment is lost.
- exec_is_branch together with exec_exception: the exception path applies and the branch is ignored.

Test Plan:
- Reset, then exec_stall_next=0, is_reg_write=1, sel=5, result=0xDEAD, next_addr=0x1004 → next cycle:
  - reg_write_en=1, sel=5, data=0xDEAD.
  - retire_valid=1, retire_next_pc=0x1004, instret=1.
- Retire with sel=0 and is_reg_write=1 → reg_write_en=0, retire_valid=1, instret increments. Then exec_stall_next=1 → reg_write_sel=0, retire_valid=0.
- Branch retire: is_branch=1, target=0x2000, next_addr=0x1008 → retire_next_pc=0x2000.
- Exception with next_addr=0x300 → one cycle later trap_valid=1, trap_next_addr=0x300, no write; the following cycle halted=1.
  - Then 5 cycles of valid exec inputs → no writes, instret unchanged.
  - Then resume=1, resume_addr=0x80 → redirect_valid=1 for one cycle, redirect_addr=0x80, halted=0.
- Load instret=all-ones by CSR write, then retire → instret=0. CSR write of 0x10 in the same cycle as a retire → instret=0x10.
- Assert rst while HALTED → all outputs return to reset values. The next valid retire commits normally.
